shot_sequencer: RTL and testbench

SHOT_SEQUENCER -- requirements
Module: shot_sequencer

---
 rtl/shot_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_shot_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_sequencer.sv
// Shot sequencer for a two-ball pool game: aim, fire, roll until the table settles or
// times out, then resolve pots into score, fouls and respawn pulses.
module shot_sequencer #(
    parameter int unsigned STILL_FRAMES = 8,
    parameter int unsigned ROLL_TIMEOUT = 600,
    parameter int unsigned WIN_SCORE    = 5
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startOfFrame,
    input  logic              shootReq,
    input  logic              newGame,
    input  logic signed [10:0] whiteBallVelX,
    input  logic signed [10:0] whiteBallVelY,
    input  logic signed [10:0] redBallVelX,
    input  logic signed [10:0] redBallVelY,
    input  logic              whiteBallHoleHit,
    input  logic              redBallHoleHit,
    input  logic [2:0]        whiteBallHoleNum,
    input  logic [2:0]        redBallHoleNum,
    output logic              aimEnable,
    output logic              collisionEnable,
    output logic              gameOver,
    output logic              shotFire,
    output logic              whiteBallRespawn,
    output logic              redBallRespawn,
    output logic [3:0]        score,
    output logic [3:0]        fouls,
    output logic [7:0]        shotCount,
    output logic [2:0]        lastRedHole
);

    localparam int unsigned StillW = $clog2(STILL_FRAMES + 1);
    localparam int unsigned FrameW = $clog2(ROLL_TIMEOUT + 1);
    localparam logic [StillW-1:0] StillMax = StillW'(STILL_FRAMES);
    localparam logic [FrameW-1:0] FrameMax = FrameW'(ROLL_TIMEOUT);
    localparam logic [3:0]        WinScore = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        StAim,
        StFire,
        StRolling,
        StSettle,
        StGameOver
    } state_e;

    state_e            state_q, state_d;
    logic [StillW-1:0] still_cnt_q, still_cnt_d;
    logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
    logic              white_potted_q, white_potted_d;
    logic              red_potted_q, red_potted_d;
    logic [3:0]        score_q, score_d;
    logic [3:0]        fouls_q, fouls_d;
    logic [7:0]        shot_count_q, shot_count_d;
    logic [2:0]        last_red_hole_q, last_red_hole_d;
    logic              stopped;

    // The white hole index has no consumer; only the hit itself matters.
    logic unused_white_hole;
    assign unused_white_hole = ^whiteBallHoleNum;

    assign stopped = (whiteBallVelX == '0) && (whiteBallVelY == '0) &&
                     (redBallVelX == '0) && (redBallVelY == '0);

    always_comb begin
        state_d          = state_q;
        still_cnt_d      = still_cnt_q;
        frame_cnt_d      = frame_cnt_q;
        white_potted_d   = white_potted_q;
        red_potted_d     = red_potted_q;
        score_d          = score_q;
        fouls_d          = fouls_q;
        shot_count_d     = shot_count_q;
        last_red_hole_d  = last_red_hole_q;
        aimEnable        = 1'b0;
        collisionEnable  = 1'b0;
        gameOver         = 1'b0;
        shotFire         = 1'b0;
        whiteBallRespawn = 1'b0;
        redBallRespawn   = 1'b0;

        unique case (state_q)
            StAim: begin
                aimEnable = 1'b1;
                if (shootReq && stopped) begin
                    state_d = StFire;
                end
            end
            StFire: begin
                shotFire = 1'b1;
                if (shot_count_q != 8'hFF) begin
                    shot_count_d = shot_count_q + 1'b1;
                end
                state_d = StRolling;
            end
            StRolling: begin
                collisionEnable = 1'b1;
                if (whiteBallHoleHit) begin
                    white_potted_d = 1'b1;
                end
                if (redBallHoleHit) begin
                    red_potted_d    = 1'b1;
                    last_red_hole_d = redBallHoleNum;
                end
                if (startOfFrame) begin
                    still_cnt_d = stopped ? still_cnt_q + 1'b1 : '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    // Compare the freshly counted values so settle follows the qualifying frame.
                    if ((still_cnt_d == StillMax) || (frame_cnt_d == FrameMax)) begin
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                whiteBallRespawn = white_potted_q;
                redBallRespawn   = red_potted_q;
                if (white_potted_q && (fouls_q != 4'hF)) begin
                    fouls_d = fouls_q + 1'b1;
                end
                if (red_potted_q && !white_potted_q && (score_q != 4'hF)) begin
                    score_d = score_q + 1'b1;
                end
                white_potted_d = 1'b0;
                red_potted_d   = 1'b0;
                still_cnt_d    = '0;
                frame_cnt_d    = '0;
                state_d        = (score_d == WinScore) ? StGameOver : StAim;
            end
            StGameOver: begin
                gameOver = 1'b1;
            end
            default: begin
                state_d = StAim;
            end
        endcase

        // Restart overrides everything else, including a simultaneous shot request.
        if (newGame) begin
            state_d         = StAim;
            still_cnt_d     = '0;
            frame_cnt_d     = '0;
            white_potted_d  = 1'b0;
            red_potted_d    = 1'b0;
            score_d         = '0;
            fouls_d         = '0;
            shot_count_d    = '0;
            last_red_hole_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= StAim;
            still_cnt_q     <= '0;
            frame_cnt_q     <= '0;
            white_potted_q  <= 1'b0;
            red_potted_q    <= 1'b0;
            score_q         <= '0;
            fouls_q         <= '0;
            shot_count_q    <= '0;
            last_red_hole_q <= '0;
        end else begin
            state_q         <= state_d;
            still_cnt_q     <= still_cnt_d;
            frame_cnt_q     <= frame_cnt_d;
            white_potted_q  <= white_potted_d;
            red_potted_q    <= red_potted_d;
            score_q         <= score_d;
            fouls_q         <= fouls_d;
            shot_count_q    <= shot_count_d;
            last_red_hole_q <= last_red_hole_d;
        end
    end

    assign score       = score_q;
    assign fouls       = fouls_q;
    assign shotCount   = shot_count_q;
    assign lastRedHole = last_red_hole_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Directed bench for shot_sequencer: a vector table for the basic shot flow plus
// hand-written sequences for game over, roll timeout and reset during a roll.
module tb_shot_sequencer;

    typedef struct packed {
        logic        sof;
        logic        shoot;
        logic        ng;
        logic [10:0] wvx;
        logic [10:0] wvy;
        logic [10:0] rvx;
        logic [10:0] rvy;
        logic        wh;
        logic        rh;
        logic [2:0]  wn;
        logic [2:0]  rn;
    } in_t;

    typedef struct packed {
        logic       aim;
        logic       coll;
        logic       go;
        logic       fire;
        logic       wr;
        logic       rr;
        logic [3:0] score;
        logic [3:0] fouls;
        logic [7:0] shots;
        logic [2:0] lrh;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic              clk;
    logic              resetN;
    logic              startOfFrame;
    logic              shootReq;
    logic              newGame;
    logic signed [10:0] whiteBallVelX;
    logic signed [10:0] whiteBallVelY;
    logic signed [10:0] redBallVelX;
    logic signed [10:0] redBallVelY;
    logic              whiteBallHoleHit;
    logic              redBallHoleHit;
    logic [2:0]        whiteBallHoleNum;
    logic [2:0]        redBallHoleNum;
    logic              aimEnable;
    logic              collisionEnable;
    logic              gameOver;
    logic              shotFire;
    logic              whiteBallRespawn;
    logic              redBallRespawn;
    logic [3:0]        score;
    logic [3:0]        fouls;
    logic [7:0]        shotCount;
    logic [2:0]        lastRedHole;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];

    // Reference counters for the hand-written sequences.
    logic [3:0] m_s, m_f;
    logic [7:0] m_n;
    logic [2:0] m_l;

    shot_sequencer dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .shootReq         (shootReq),
        .newGame          (newGame),
        .whiteBallVelX    (whiteBallVelX),
        .whiteBallVelY    (whiteBallVelY),
        .redBallVelX      (redBallVelX),
        .redBallVelY      (redBallVelY),
        .whiteBallHoleHit (whiteBallHoleHit),
        .redBallHoleHit   (redBallHoleHit),
        .whiteBallHoleNum (whiteBallHoleNum),
        .redBallHoleNum   (redBallHoleNum),
        .aimEnable        (aimEnable),
        .collisionEnable  (collisionEnable),
        .gameOver         (gameOver),
        .shotFire         (shotFire),
        .whiteBallRespawn (whiteBallRespawn),
        .redBallRespawn   (redBallRespawn),
        .score            (score),
        .fouls            (fouls),
        .shotCount        (shotCount),
        .lastRedHole      (lastRedHole)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(logic sof, logic shoot, logic ng, logic [10:0] v,
                               logic [3:0] which, logic wh, logic rh, logic [2:0] rn);
        in_t x;
        x.sof   = sof;
        x.shoot = shoot;
        x.ng    = ng;
        x.wvx   = which[0] ? v : 11'd0;
        x.wvy   = which[1] ? v : 11'd0;
        x.rvx   = which[2] ? v : 11'd0;
        x.rvy   = which[3] ? v : 11'd0;
        x.wh    = wh;
        x.rh    = rh;
        x.wn    = 3'd4;
        x.rn    = rn;
        return x;
    endfunction

    function automatic exp_t mke(logic aim, logic coll, logic go, logic fire, logic wr, logic rr,
                                 logic [3:0] s, logic [3:0] f, logic [7:0] n, logic [2:0] l);
        exp_t e;
        e.aim   = aim;
        e.coll  = coll;
        e.go    = go;
        e.fire  = fire;
        e.wr    = wr;
        e.rr    = rr;
        e.score = s;
        e.fouls = f;
        e.shots = n;
        e.lrh   = l;
        return e;
    endfunction

    task automatic apply(in_t x);
        startOfFrame     = x.sof;
        shootReq         = x.shoot;
        newGame          = x.ng;
        whiteBallVelX    = x.wvx;
        whiteBallVelY    = x.wvy;
        redBallVelX      = x.rvx;
        redBallVelY      = x.rvy;
        whiteBallHoleHit = x.wh;
        redBallHoleHit   = x.rh;
        whiteBallHoleNum = x.wn;
        redBallHoleNum   = x.rn;
    endtask

    task automatic step(in_t x);
        apply(x);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, exp_t e);
        exp_t a;
        a = mke(aimEnable, collisionEnable, gameOver, shotFire, whiteBallRespawn, redBallRespawn,
                score, fouls, shotCount, lastRedHole);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got aim=%b coll=%b go=%b fire=%b wr=%b rr=%b sc=%0d fo=%0d sh=%0d lrh=%0d; want aim=%b coll=%b go=%b fire=%b wr=%b rr=%b sc=%0d fo=%0d sh=%0d lrh=%0d",
                     name, a.aim, a.coll, a.go, a.fire, a.wr, a.rr, a.score, a.fouls, a.shots,
                     a.lrh, e.aim, e.coll, e.go, e.fire, e.wr, e.rr, e.score, e.fouls, e.shots,
                     e.lrh);
        end
    endtask

    task automatic add(in_t i, exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic fill();
        in_t idle, sof0, fire;
        idle = mk(0, 0, 0, 11'd0, 4'd0, 0, 0, 3'd0);
        sof0 = mk(1, 0, 0, 11'd0, 4'd0, 0, 0, 3'd0);
        fire = mk(0, 1, 0, 11'd0, 4'd0, 0, 0, 3'd0);
        add(idle, mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Any single nonzero velocity blocks the shot.
        for (int k = 0; k < 4; k++) begin
            add(mk(0, 1, 0, -11'sd5, 4'(1 << k), 0, 0, 3'd0), mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        add(fire, mke(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        add(idle, mke(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 7; k++) add(sof0, mke(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        add(sof0, mke(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        add(idle, mke(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // Red pot held 4 cycles, with a moving frame that must clear the still count.
        add(fire, mke(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
        add(idle, mke(0, 1, 0, 0, 0, 0, 0, 0, 2, 0));
        add(mk(1, 0, 0, 11'd3, 4'd1, 0, 0, 3'd0), mke(0, 1, 0, 0, 0, 0, 0, 0, 2, 0));
        for (int k = 0; k < 4; k++) begin
            add(mk(0, 0, 0, 11'd0, 4'd0, 0, 1, 3'd3), mke(0, 1, 0, 0, 0, 0, 0, 0, 2, 3));
        end
        for (int k = 0; k < 4; k++) add(sof0, mke(0, 1, 0, 0, 0, 0, 0, 0, 2, 3));
        add(mk(1, 0, 0, 11'd2, 4'd8, 0, 0, 3'd0), mke(0, 1, 0, 0, 0, 0, 0, 0, 2, 3));
        for (int k = 0; k < 7; k++) add(sof0, mke(0, 1, 0, 0, 0, 0, 0, 0, 2, 3));
        add(sof0, mke(0, 0, 0, 0, 0, 1, 0, 0, 2, 3));
        add(idle, mke(1, 0, 0, 0, 0, 0, 1, 0, 2, 3));
        // Hits while aiming are ignored: the following shot resolves with no pots.
        add(mk(0, 0, 0, 11'd0, 4'd0, 1, 1, 3'd5), mke(1, 0, 0, 0, 0, 0, 1, 0, 2, 3));
        add(fire, mke(0, 0, 0, 1, 0, 0, 1, 0, 2, 3));
        add(idle, mke(0, 1, 0, 0, 0, 0, 1, 0, 3, 3));
        for (int k = 0; k < 7; k++) add(sof0, mke(0, 1, 0, 0, 0, 0, 1, 0, 3, 3));
        add(sof0, mke(0, 0, 0, 0, 0, 0, 1, 0, 3, 3));
        add(idle, mke(1, 0, 0, 0, 0, 0, 1, 0, 3, 3));
        // Both balls potted together: foul, no score.
        add(fire, mke(0, 0, 0, 1, 0, 0, 1, 0, 3, 3));
        add(idle, mke(0, 1, 0, 0, 0, 0, 1, 0, 4, 3));
        add(mk(0, 0, 0, 11'd0, 4'd0, 1, 1, 3'd1), mke(0, 1, 0, 0, 0, 0, 1, 0, 4, 1));
        for (int k = 0; k < 7; k++) add(sof0, mke(0, 1, 0, 0, 0, 0, 1, 0, 4, 1));
        add(sof0, mke(0, 0, 0, 0, 1, 1, 1, 0, 4, 1));
        add(idle, mke(1, 0, 0, 0, 0, 0, 1, 1, 4, 1));
        // Restart beats a simultaneous shot request.
        add(mk(0, 1, 1, 11'd0, 4'd0, 0, 0, 3'd0), mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic run_shot(logic red, logic white, logic [2:0] rn);
        in_t idle;
        idle = mk(0, 0, 0, 11'd0, 4'd0, 0, 0, 3'd0);
        step(mk(0, 1, 0, 11'd0, 4'd0, 0, 0, 3'd0));
        chk("shot_fire", mke(0, 0, 0, 1, 0, 0, m_s, m_f, m_n, m_l));
        if (m_n != 8'hFF) m_n = m_n + 1'b1;
        step(idle);
        chk("shot_roll", mke(0, 1, 0, 0, 0, 0, m_s, m_f, m_n, m_l));
        step(mk(0, 0, 0, 11'd0, 4'd0, white, red, rn));
        if (red) m_l = rn;
        for (int k = 0; k < 8; k++) begin
            step(mk(1, 0, 0, 11'd0, 4'd0, 0, 0, 3'd0));
            if (k == 6) chk("shot_still7", mke(0, 1, 0, 0, 0, 0, m_s, m_f, m_n, m_l));
            if (k == 7) chk("shot_settle", mke(0, 0, 0, 0, white, red, m_s, m_f, m_n, m_l));
        end
        if (white && m_f != 4'hF) m_f = m_f + 1'b1;
        if (red && !white && m_s != 4'hF) m_s = m_s + 1'b1;
        step(idle);
        if (m_s == 4'd5) chk("shot_over", mke(0, 0, 1, 0, 0, 0, m_s, m_f, m_n, m_l));
        else chk("shot_aim", mke(1, 0, 0, 0, 0, 0, m_s, m_f, m_n, m_l));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t idle;
        idle = mk(0, 0, 0, 11'd0, 4'd0, 0, 0, 3'd0);
        resetN = 1'b0;
        apply(idle);
        fill();
        #12;
        chk("reset_state", mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        resetN = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].i);
            chk($sformatf("vec%0d", i), tbl[i].e);
        end

        // Play to the winning score, with one white-only foul along the way.
        m_s = 0; m_f = 0; m_n = 0; m_l = 0;
        run_shot(1, 0, 3'd2);
        run_shot(0, 1, 3'd0);
        run_shot(1, 0, 3'd4);
        run_shot(1, 0, 3'd0);
        run_shot(1, 0, 3'd5);
        run_shot(1, 0, 3'd6);
        step(mk(0, 1, 0, 11'd0, 4'd0, 0, 0, 3'd0));
        chk("over_shoot", mke(0, 0, 1, 0, 0, 0, 5, 1, 6, 6));
        step(idle);
        chk("over_hold", mke(0, 0, 1, 0, 0, 0, 5, 1, 6, 6));
        step(mk(0, 0, 1, 11'd0, 4'd0, 0, 0, 3'd0));
        chk("over_newgame", mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Roll timeout with the white ball never stopping.
        step(mk(0, 1, 0, 11'd0, 4'd0, 0, 0, 3'd0));
        chk("to_fire", mke(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        step(idle);
        chk("to_roll", mke(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int f = 1; f <= 600; f++) begin
            step(mk(1, 0, 0, 11'd1, 4'd1, 0, 0, 3'd0));
            if (f == 599) chk("to_frame599", mke(0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
            if (f == 600) chk("to_frame600", mke(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
            if (f < 600) step(mk(0, 0, 0, 11'd1, 4'd1, 0, 0, 3'd0));
        end
        step(mk(0, 0, 0, 11'd1, 4'd1, 0, 0, 3'd0));
        chk("to_aim", mke(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(mk(0, 1, 0, 11'd1, 4'd1, 0, 0, 3'd0));
        chk("to_moving_shoot", mke(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(mk(0, 0, 0, 11'd1, 4'd1, 0, 0, 3'd0));
        chk("to_no_fire", mke(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        // Reset during a roll with a red pot pending.
        step(mk(0, 1, 0, 11'd0, 4'd0, 0, 0, 3'd0));
        step(idle);
        step(mk(0, 0, 0, 11'd0, 4'd0, 0, 1, 3'd2));
        chk("rst_pending", mke(0, 1, 0, 0, 0, 0, 0, 0, 2, 2));
        resetN = 1'b0;
        #1;
        chk("rst_async", mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        resetN = 1'b1;
        step(idle);
        chk("rst_release", mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, 11'd0, 4'd0, 0, 0, 3'd0));
        chk("rst_no_respawn", mke(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
